// File: rtl/row_vector_feeder.sv
// Streams matrix-row and vector chunks from two synchronous RAMs to the
// row-by-vector dot-product unit, tagging each chunk with its row and last-chunk flag.
module row_vector_feeder #(
   parameter int LANES  = 3,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      number_of_rows,
   input  logic [CNT_W-1:0]      number_of_multiples,
   input  logic                  hold,
   output logic [ADDR_W-1:0]     mat_addr,
   output logic [ADDR_W-1:0]     vec_addr,
   output logic                  mem_en,
   input  logic [32*LANES-1:0]   mat_data,
   input  logic [32*LANES-1:0]   vec_data,
   output logic [32*LANES-1:0]   a,
   output logic [32*LANES-1:0]   p,
   output logic                  start_row_by_vector,
   output logic                  last_chunk,
   output logic [CNT_W-1:0]      row_index,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    rows_q, rows_d;
   logic [CNT_W-1:0]    mults_q, mults_d;
   logic [CNT_W-1:0]    row_q, row_d;
   logic [CNT_W-1:0]    k_q, k_d;
   logic [ADDR_W-1:0]   lin_q, lin_d;
   logic                valid_q, valid_d;
   logic [CNT_W-1:0]    row_tag_q, row_tag_d;
   logic                last_tag_q, last_tag_d;

   logic                fetch;
   logic                last_k;
   logic                last_row;

   assign last_k   = (k_q == mults_q - CNT_W'(1));
   assign last_row = (row_q == rows_q - CNT_W'(1));

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      mults_d    = mults_q;
      row_d      = row_q;
      k_d        = k_q;
      lin_d      = lin_q;
      valid_d    = valid_q;
      row_tag_d  = row_tag_q;
      last_tag_d = last_tag_q;
      fetch      = 1'b0;
      mem_en     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((number_of_rows != '0) && (number_of_multiples != '0)) begin
                  rows_d  = number_of_rows;
                  mults_d = number_of_multiples;
                  row_d   = '0;
                  k_d     = '0;
                  lin_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  // Empty pass: the drain stage is already empty, so this only
                  // aligns the done pulse to two cycles after start.
                  state_d = S_DRAIN;
               end
            end
         end
         S_FETCH: begin
            busy   = 1'b1;
            mem_en = ~hold;
            if (!hold) begin
               fetch = 1'b1;
               lin_d = lin_q + ADDR_W'(1);
               if (last_k) begin
                  k_d   = '0;
                  row_d = row_q + CNT_W'(1);
               end else begin
                  k_d = k_q + CNT_W'(1);
               end
               if (last_k && last_row) begin
                  row_d   = '0;
                  k_d     = '0;
                  lin_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            // Leave once the final chunk is being handed downstream this cycle.
            if (!valid_q || !hold) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Valid/tag stage mirrors the one-cycle RAM latency and freezes with it.
      if (!hold) begin
         valid_d = fetch;
         if (fetch) begin
            row_tag_d  = row_q;
            last_tag_d = last_k;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         mults_q    <= '0;
         row_q      <= '0;
         k_q        <= '0;
         lin_q      <= '0;
         valid_q    <= 1'b0;
         row_tag_q  <= '0;
         last_tag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         mults_q    <= mults_d;
         row_q      <= row_d;
         k_q        <= k_d;
         lin_q      <= lin_d;
         valid_q    <= valid_d;
         row_tag_q  <= row_tag_d;
         last_tag_q <= last_tag_d;
      end
   end

   assign mat_addr            = lin_q;
   assign vec_addr            = ADDR_W'(k_q);
   assign a                   = mat_data;
   assign p                   = vec_data;
   assign start_row_by_vector = valid_q & ~hold;
   assign last_chunk          = valid_q & ~hold & last_tag_q;
   assign row_index           = row_tag_q;

endmodule
